// File: rtl/keep_alive_master.sv
// keep_alive_master: host-side keep-alive initiator.
// Pings through the TX arbiter, times the reply and tracks link health.
module keep_alive_master #(
  parameter int PERIOD     = 1000000,
  parameter int TIMEOUT    = 100000,
  parameter int MAX_MISS   = 3,
  parameter bit SEND_RESET = 1'b1
) (
  input  logic        n_rst,
  input  logic        clk,
  input  logic        enable,
  input  logic [7:0]  rx_data,
  input  logic        rx_ena,
  output logic        have_msg,
  input  logic        rdreq,
  output logic [7:0]  data_out,
  output logic [7:0]  len,
  output logic        link_ok,
  output logic        link_lost,
  output logic [3:0]  miss_cnt,
  output logic [15:0] rtt,
  output logic        rtt_valid
);

  localparam logic [7:0] B_PING  = 8'hAE;
  localparam logic [7:0] B_REPLY = 8'hEA;
  localparam logic [7:0] B_RESET = 8'hF0;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [TW-1:0] TMO   = TW'(TIMEOUT);
  localparam logic [PW-1:0] PLAST = PW'(PERIOD - 1);
  localparam logic [3:0]    MMAX  = 4'(MAX_MISS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PING_REQ,
    S_WAIT_REPLY,
    S_RST_REQ,
    S_WAIT_PERIOD
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [PW-1:0] r_per;
  logic          r_have;
  logic [7:0]    r_data;
  logic          r_ok;
  logic          r_lost;
  logic [3:0]    r_miss;
  logic [15:0]   r_rtt;
  logic          r_rtt_valid;

  logic [TW-1:0] w_tick;
  logic [31:0]   w_tick32;
  logic [15:0]   w_rtt;
  logic          w_reply;
  logic          w_tmo;
  logic [3:0]    w_miss_inc;

  // Timer value seen in the current WAIT_REPLY cycle (1 on the first)
  assign w_tick     = r_timer + TW'(1);
  assign w_tick32   = 32'(w_tick);
  assign w_rtt      = (w_tick32 > 32'h0000_FFFF) ? 16'hFFFF : w_tick32[15:0];
  assign w_reply    = rx_ena && (rx_data == B_REPLY);
  assign w_tmo      = (w_tick == TMO);
  assign w_miss_inc = (r_miss == 4'hF) ? 4'hF : r_miss + 4'd1;

  assign have_msg  = r_have;
  assign data_out  = r_data;
  assign len       = 8'h01;
  assign link_ok   = r_ok;
  assign link_lost = r_lost;
  assign miss_cnt  = r_miss;
  assign rtt       = r_rtt;
  assign rtt_valid = r_rtt_valid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_per       <= '0;
      r_have      <= 1'b0;
      r_data      <= B_PING;
      r_ok        <= 1'b0;
      r_lost      <= 1'b0;
      r_miss      <= 4'd0;
      r_rtt       <= 16'd0;
      r_rtt_valid <= 1'b0;
    end else begin
      r_rtt_valid <= 1'b0;
      if (!enable) begin
        // Abort: drop any pending byte, keep only the last rtt
        r_state <= S_IDLE;
        r_timer <= '0;
        r_per   <= '0;
        r_have  <= 1'b0;
        r_data  <= B_PING;
        r_ok    <= 1'b0;
        r_lost  <= 1'b0;
        r_miss  <= 4'd0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state <= S_PING_REQ;
            r_have  <= 1'b1;
            r_data  <= B_PING;
          end
          S_PING_REQ: begin
            if (rdreq) begin
              r_state <= S_WAIT_REPLY;
              r_have  <= 1'b0;
              r_timer <= '0;
            end
          end
          S_WAIT_REPLY: begin
            r_timer <= w_tick;
            if (w_reply) begin
              r_rtt       <= w_rtt;
              r_rtt_valid <= 1'b1;
              r_miss      <= 4'd0;
              r_ok        <= 1'b1;
              r_lost      <= 1'b0;
              r_per       <= '0;
              r_state     <= S_WAIT_PERIOD;
            end else if (w_tmo) begin
              r_miss <= w_miss_inc;
              r_ok   <= 1'b0;
              r_per  <= '0;
              if (w_miss_inc >= MMAX) begin
                r_lost <= 1'b1;
                if (SEND_RESET) begin
                  r_state <= S_RST_REQ;
                  r_have  <= 1'b1;
                  r_data  <= B_RESET;
                end else begin
                  r_state <= S_WAIT_PERIOD;
                end
              end else begin
                r_state <= S_WAIT_PERIOD;
              end
            end
          end
          S_RST_REQ: begin
            if (rdreq) begin
              r_state <= S_WAIT_PERIOD;
              r_have  <= 1'b0;
              r_data  <= B_PING;
              r_miss  <= 4'd0;
              r_per   <= '0;
            end
          end
          S_WAIT_PERIOD: begin
            if (r_per == PLAST) begin
              r_state <= S_PING_REQ;
              r_have  <= 1'b1;
              r_data  <= B_PING;
            end else begin
              r_per <= r_per + PW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
